// File: rtl/generador_secuencia_if.sv
// Serial stimulus bus between a word source (master) and generador_secuencia (slave).
// The slave captures dato on start and drives the one-bit stream plus status flags.
interface generador_secuencia_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dato;
    logic             ciclico;
    logic             salida;
    logic             valido;
    logic             busy;
    logic             done;

    modport master (
        output start,
        output dato,
        output ciclico,
        input  salida,
        input  valido,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  dato,
        input  ciclico,
        output salida,
        output valido,
        output busy,
        output done
    );
endinterface

// File: rtl/generador_secuencia.sv
// Parallel-to-serial source: sends a captured WIDTH-bit word LSB-first on salida,
// holding each bit DIV cycles, optionally repeating the stored word back-to-back.
module generador_secuencia #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    generador_secuencia_if.slave  bus
);

    localparam int unsigned BitW = $clog2(WIDTH);
    localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e            r_state;
    logic [WIDTH-1:0]  r_shift;
    logic [WIDTH-1:0]  r_word;
    logic [BitW-1:0]   r_bit;
    logic              r_salida;
    logic              r_valido;
    logic              r_busy;
    logic              r_done;
    logic              w_div_last;
    logic              w_bit_last;

    // The divider idles at zero outside SHIFT, so it is already clear when a word starts.
    if (DIV > 1) begin : g_div
        logic [DivW-1:0] r_div;

        always_ff @(posedge clk) begin
            if (!reset) begin
                r_div <= '0;
            end else if (r_state != StShift || r_div == DivW'(DIV - 1)) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + 1'b1;
            end
        end

        assign w_div_last = (r_div == DivW'(DIV - 1));
    end else begin : g_no_div
        assign w_div_last = 1'b1;
    end

    assign w_bit_last = (r_bit == BitW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= StIdle;
            r_shift  <= '0;
            r_word   <= '0;
            r_bit    <= '0;
            r_salida <= 1'b0;
            r_valido <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_salida <= 1'b0;
                    r_valido <= 1'b0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                    if (bus.start) begin
                        r_shift  <= bus.dato;
                        r_word   <= bus.dato;
                        r_bit    <= '0;
                        r_salida <= bus.dato[0];
                        r_valido <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= StShift;
                    end
                end
                StShift: begin
                    if (w_div_last) begin
                        if (!w_bit_last) begin
                            r_shift  <= r_shift >> 1;
                            r_salida <= r_shift[1];
                            r_bit    <= r_bit + 1'b1;
                        end else if (bus.ciclico) begin
                            // Reload from the stored copy so a changing dato cannot corrupt the loop.
                            r_shift  <= r_word;
                            r_salida <= r_word[0];
                            r_bit    <= '0;
                        end else begin
                            r_salida <= 1'b0;
                            r_valido <= 1'b0;
                            r_done   <= 1'b1;
                            r_bit    <= '0;
                            r_state  <= StDone;
                        end
                    end
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.salida = r_salida;
    assign bus.valido = r_valido;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;

endmodule

// File: tb/tb_generador_secuencia.sv
// Directed bench for generador_secuencia: one DUT with DIV=1 and one with DIV=3,
// inputs driven and outputs sampled on the falling clock edge.
module tb_generador_secuencia;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    generador_secuencia_if #(.WIDTH(8)) if1 ();
    generador_secuencia_if #(.WIDTH(8)) if3 ();

    generador_secuencia #(.WIDTH(8), .DIV(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1.slave)
    );

    generador_secuencia #(.WIDTH(8), .DIV(3)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (if3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        if1.start = 1'b1; if1.dato = 8'hFF; if1.ciclico = 1'b0;
        if3.start = 1'b1; if3.dato = 8'hFF; if3.ciclico = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({if1.salida, if1.valido, if1.busy, if1.done} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_hold1 cyc=%0d got=%b exp=0000", i,
                         {if1.salida, if1.valido, if1.busy, if1.done});
            end
            n_checks++;
            if ({if3.salida, if3.valido, if3.busy, if3.done} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_hold3 cyc=%0d got=%b exp=0000", i,
                         {if3.salida, if3.valido, if3.busy, if3.done});
            end
        end
        reset = 1'b1;
        if1.start = 1'b0;
        if3.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({if1.salida, if1.valido, if1.busy, if1.done} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d got=%b exp=0000", i,
                         {if1.salida, if1.valido, if1.busy, if1.done});
            end
        end
    endtask

    task automatic test_oneshot();
        logic [7:0] w;
        w = 8'b1011_0010;
        if1.dato = w; if1.start = 1'b1;
        tick();
        if1.start = 1'b0; if1.dato = 8'h00;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if ({if1.salida, if1.valido, if1.busy, if1.done} !== {w[i], 3'b110}) begin
                n_fail++;
                $display("FAIL oneshot_bit%0d got=%b exp=%b", i,
                         {if1.salida, if1.valido, if1.busy, if1.done}, {w[i], 3'b110});
            end
            tick();
        end
        n_checks++;
        if ({if1.salida, if1.valido, if1.busy, if1.done} !== 4'b0011) begin
            n_fail++;
            $display("FAIL oneshot_done got=%b exp=0011",
                     {if1.salida, if1.valido, if1.busy, if1.done});
        end
        tick();
        n_checks++;
        if ({if1.salida, if1.valido, if1.busy, if1.done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL oneshot_idle got=%b exp=0000",
                     {if1.salida, if1.valido, if1.busy, if1.done});
        end
    endtask

    task automatic test_divider();
        logic [7:0] w;
        w = 8'hA5;
        if3.dato = w; if3.start = 1'b1;
        tick();
        if3.start = 1'b0;
        for (int j = 0; j < 24; j++) begin
            n_checks++;
            if ({if3.salida, if3.valido, if3.busy, if3.done} !== {w[j/3], 3'b110}) begin
                n_fail++;
                $display("FAIL div_cyc%0d got=%b exp=%b", j,
                         {if3.salida, if3.valido, if3.busy, if3.done}, {w[j/3], 3'b110});
            end
            tick();
        end
        n_checks++;
        if ({if3.salida, if3.valido, if3.busy, if3.done} !== 4'b0011) begin
            n_fail++;
            $display("FAIL div_done got=%b exp=0011",
                     {if3.salida, if3.valido, if3.busy, if3.done});
        end
        tick();
        n_checks++;
        if (if3.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL div_busy_low got=%b exp=0", if3.busy);
        end
    endtask

    task automatic test_isolation();
        logic [7:0] w;
        int         n_done;
        w = 8'h0F;
        n_done = 0;
        if1.dato = w; if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if ({if1.salida, if1.valido} !== {w[i], 1'b1}) begin
                n_fail++;
                $display("FAIL iso_bit%0d got=%b exp=%b", i, {if1.salida, if1.valido},
                         {w[i], 1'b1});
            end
            if (i == 3) begin
                if1.start = 1'b1; if1.dato = 8'hFF;
            end
            if (i == 5) if1.start = 1'b0;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            if (if1.done === 1'b1) n_done++;
            tick();
        end
        n_checks++;
        if (n_done != 1) begin
            n_fail++;
            $display("FAIL iso_done_count got=%0d exp=1", n_done);
        end
        n_checks++;
        if (if1.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL iso_busy_end got=%b exp=0", if1.busy);
        end
    endtask

    task automatic test_cyclic();
        logic [7:0] w;
        w = 8'h81;
        if1.dato = w; if1.ciclico = 1'b1; if1.start = 1'b1;
        tick();
        if1.start = 1'b0; if1.dato = 8'h00;
        for (int m = 0; m < 4; m++) begin
            for (int b = 0; b < 8; b++) begin
                n_checks++;
                if ({if1.salida, if1.valido, if1.busy, if1.done} !== {w[b], 3'b110}) begin
                    n_fail++;
                    $display("FAIL cyc_w%0d_b%0d got=%b exp=%b", m, b,
                             {if1.salida, if1.valido, if1.busy, if1.done}, {w[b], 3'b110});
                end
                if (m == 3 && b == 2) if1.ciclico = 1'b0;
                tick();
            end
        end
        n_checks++;
        if ({if1.salida, if1.valido, if1.busy, if1.done} !== 4'b0011) begin
            n_fail++;
            $display("FAIL cyc_done got=%b exp=0011",
                     {if1.salida, if1.valido, if1.busy, if1.done});
        end
        tick();
        n_checks++;
        if (if1.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cyc_busy_low got=%b exp=0", if1.busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] w;
        logic [7:0] w2;
        w  = 8'hC6;
        w2 = 8'h3C;
        if1.dato = w; if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (if1.salida !== w[i]) begin
                n_fail++;
                $display("FAIL rmid_bit%0d got=%b exp=%b", i, if1.salida, w[i]);
            end
            if (i == 4) reset = 1'b0;
            tick();
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({if1.salida, if1.valido, if1.busy, if1.done} !== 4'b0000) begin
                n_fail++;
                $display("FAIL rmid_quiet cyc=%0d got=%b exp=0000", i,
                         {if1.salida, if1.valido, if1.busy, if1.done});
            end
            tick();
        end
        if1.dato = w2; if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if ({if1.salida, if1.valido, if1.done} !== {w2[i], 2'b10}) begin
                n_fail++;
                $display("FAIL rmid_new_bit%0d got=%b exp=%b", i,
                         {if1.salida, if1.valido, if1.done}, {w2[i], 2'b10});
            end
            tick();
        end
        n_checks++;
        if (if1.done !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_new_done got=%b exp=1", if1.done);
        end
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_oneshot();
        test_divider();
        test_isolation();
        test_cyclic();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/generador_secuencia.md
# generador_secuencia

Parallel-to-serial stimulus source that sits directly upstream of the sequence detector. It captures a WIDTH-bit word on a start request and emits it LSB-first as a one-bit stream on `salida`, which drives the detector's `entrada`. Each bit is held for a programmable number of clock cycles. Continuous (cyclic) mode lets a board build feed the detector a repeating pattern from switches without a testbench.

## Interface
Parameters:
- `WIDTH`, default 8: bits per word; legal range ≥ 2.
- `DIV`, default 1: clock cycles each bit is held on `salida`; legal range ≥ 1.

Ports:
- `clk`  input  1  system clock; all logic is on the rising edge.
- `reset`  input  1  synchronous, active-low reset. `reset==0` at a rising edge resets the block.
- `start`  input  1  level-sampled request; honoured only in IDLE.
- `dato`  input  WIDTH  word to serialise; sampled only at the edge that accepts `start`.
- `ciclico`  input  1  1 = repeat the captured word back-to-back; 0 = send it once.
- `salida`  output  1  serial bit to the detector's `entrada`.
- `valido`  output  1  high while `salida` carries a word bit.
- `busy`  output  1  high in any state other than IDLE.
- `done`  output  1  one-cycle pulse after the final word completes.

## Operation
- All outputs are registered. Internal registers: state, shift register (WIDTH), stored copy of the word (WIDTH), bit counter (ceil(log2 WIDTH)), divider counter (ceil(log2 DIV), or none when DIV=1).
- Reset (`reset==0` at an edge):
  - state ← IDLE; all counters and registers ← 0.
  - `salida`=0, `valido`=0, `busy`=0, `done`=0 from the following cycle.
  - Reset overrides every other input and aborts a word in flight; no `done` is produced for an aborted word.
- IDLE:
  - Outputs all 0.
  - If `start==1`: load `dato` into the shift register and the stored copy, clear both counters, go to SHIFT.
- SHIFT:
  - `salida`=shift[0]; `valido`=1; `busy`=1.
  - The divider counts 0..DIV-1. At DIV-1 it wraps to 0, the shift register shifts right one place, and the bit counter increments.
  - When the bit counter is at WIDTH-1 and the divider is at DIV-1 (last cycle of the last bit):
    - if `ciclico==1`: reload the shift register from the stored copy (not from live `dato`), clear both counters, stay in SHIFT. There is no gap cycle between words.
    - else: go to DONE.
  - `ciclico` is examined only on that last cycle. Dropping it mid-word lets the current word finish and then end the transfer.
  - `start` and `dato` are ignored.
- DONE:
  - `done`=1, `busy`=1, `salida`=0, `valido`=0 for exactly one cycle, then return to IDLE.
  - `start` is ignored in this state.

## Timing
- `start` is sampled high at edge N:
  - After edge N: `salida`=`dato[0]`, `valido`=1, `busy`=1.
  - Bit k occupies the cycles after edges N+k·DIV through N+(k+1)·DIV−1.
- Single word:
  - `done` is high after edge N+WIDTH·DIV.
  - `busy` falls after edge N+WIDTH·DIV+1.
  - The earliest next accepted `start` is at edge N+WIDTH·DIV+1.
- Cyclic mode: word m (counting from 0) begins after edge N+m·WIDTH·DIV.
- The `salida` value changes only at bit boundaries, so there are no glitches into the detector.
- Throughput (one-shot): WIDTH·DIV+1 cycles per word. Minimum request-to-request period: WIDTH·DIV+1 cycles.

## Test plan
- Reset/idle: hold `reset`=0 for 3 cycles with `start`=1 → `salida`, `valido`, `busy`, `done` all 0. Release `reset` with `start`=0 → outputs stay 0.
- One-shot, WIDTH=8, DIV=1, `dato`=8'b1011_0010, 1-cycle `start` pulse:
  - → `salida`=0,1,0,0,1,1,0,1 on 8 consecutive cycles with `valido`=1;
  - → `done`=1 on cycle 9; `busy`=0 on cycle 10.
- Divider, DIV=3, `dato`=8'hA5: each bit is held exactly 3 cycles (1,1,1,0,0,0,1,1,1,…) → `done` at cycle 25.
- Input isolation: assert `start` again and change `dato` to 8'hFF at bit 3 of an 8'h0F transfer → stream remains 1,1,1,1,0,0,0,0; only one `done`.
- Cyclic mode, DIV=1, `dato`=8'h81, `ciclico`=1:
  - → three back-to-back words with no gap (…1,1…at word seams);
  - clear `ciclico` at bit 2 of word 3 → word 3 completes, then `done`; `busy`=0 the cycle after.
- Reset mid-word: drive `reset`=0 during bit 4 → after that edge all outputs 0; no `done`; a new `start` after release begins cleanly from bit 0.
